// File: rtl/correlator_sequencer.sv
// Correlator integration sequencer: decodes UART command bytes and paces
// integrate / latch / clear windows, holding per-input delay taps stable inside each window.

module correlator_delay_lane #(
  parameter int DELAY_BITS = 20,
  parameter int RW         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  nib_we,
  input  logic [RW-1:0]         nib_sel,
  input  logic [3:0]            nib,
  input  logic                  load,
  output logic [DELAY_BITS-1:0] tap
);
  localparam int DN = DELAY_BITS / 4;

  logic [DELAY_BITS-1:0] pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      tap     <= '0;
    end else begin
      if (load) tap <= pending;
      for (int k = 0; k < DN; k++)
        if (nib_we && nib_sel == RW'(k)) pending[k*4 +: 4] <= nib;
    end
  end
endmodule

module correlator_sequencer #(
  parameter int NUM_INPUTS  = 4,
  parameter int DELAY_BITS  = 20,
  parameter int PERIOD_BITS = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  input  logic                             tx_busy,
  output logic [NUM_INPUTS*DELAY_BITS-1:0] delay,
  output logic [31:0]                      leds,
  output logic [3:0]                       baud_rate,
  output logic                             counter_clear,
  output logic                             frame_latch,
  output logic                             tx_start,
  output logic [7:0]                       overrun,
  output logic [1:0]                       state
);
  localparam int DN   = DELAY_BITS / 4;
  localparam int PN   = PERIOD_BITS / 4;
  localparam int MAXN = (DN > PN) ? DN : PN;
  localparam int RW   = $clog2(MAXN + 1);

  localparam logic [3:0] OP_CLEAR      = 4'd0;
  localparam logic [3:0] OP_SET_INDEX  = 4'd1;
  localparam logic [3:0] OP_SET_LEDS   = 4'd2;
  localparam logic [3:0] OP_SET_BAUD   = 4'd3;
  localparam logic [3:0] OP_SET_DELAY  = 4'd4;
  localparam logic [3:0] OP_SET_PERIOD = 4'd5;
  localparam logic [3:0] OP_ENABLE     = 4'd13;

  typedef enum logic [1:0] {IDLE = 2'd0, INTEGRATE = 2'd1, LATCH = 2'd2, CLEAR = 2'd3} state_t;

  state_t                 st;
  logic [3:0]             op, arg, index;
  logic [RW-1:0]          ridx;
  logic                   capture_en;
  logic [PERIOD_BITS-1:0] period, cnt, last_cnt;
  logic                   idx_ok, dly_wr, xfer;
  logic [NUM_INPUTS-1:0][DELAY_BITS-1:0] taps;

  assign op     = rx_data[3:0];
  assign arg    = rx_data[7:4];
  assign idx_ok = int'({1'b0, index}) < NUM_INPUTS;
  assign dly_wr = rx_valid && op == OP_SET_DELAY && ridx < RW'(DN) && idx_ok;
  // Taps move only on window entry or in CLEAR, so a window never sees a delay change.
  assign xfer   = (st == IDLE && capture_en) || st == CLEAR;
  assign last_cnt = (period < PERIOD_BITS'(2)) ? PERIOD_BITS'(1) : period - PERIOD_BITS'(1);
  assign delay  = taps;
  assign state  = st;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    correlator_delay_lane #(.DELAY_BITS(DELAY_BITS), .RW(RW)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .nib_we  (dly_wr && int'({1'b0, index}) == g),
      .nib_sel (ridx),
      .nib     (arg),
      .load    (xfer),
      .tap     (taps[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index      <= '0;
      ridx       <= '0;
      leds       <= '0;
      baud_rate  <= '0;
      period     <= '0;
      capture_en <= 1'b0;
    end else if (rx_valid) begin
      case (op)
        OP_CLEAR:     ridx <= '0;
        OP_SET_INDEX: index <= arg;
        OP_SET_LEDS:  leds[{index, 1'b0} +: 2] <= arg[1:0];
        OP_SET_BAUD:  baud_rate <= arg;
        OP_SET_DELAY: if (ridx < RW'(DN) && idx_ok) ridx <= ridx + RW'(1);
        OP_SET_PERIOD:
          if (ridx < RW'(PN)) begin
            for (int k = 0; k < PN; k++)
              if (ridx == RW'(k)) period[k*4 +: 4] <= arg;
            ridx <= ridx + RW'(1);
          end
        OP_ENABLE:    capture_en <= arg[0];
        default: ;
      endcase
    end
  end

  // Outputs are computed for the state being entered; tx_busy is sampled on
  // the edge into LATCH so tx_start and overrun can stay registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= IDLE;
      counter_clear <= 1'b1;
      frame_latch   <= 1'b0;
      tx_start      <= 1'b0;
      cnt           <= '0;
      overrun       <= '0;
    end else begin
      frame_latch <= 1'b0;
      tx_start    <= 1'b0;
      case (st)
        IDLE: begin
          counter_clear <= 1'b1;
          if (capture_en) begin
            st            <= INTEGRATE;
            cnt           <= '0;
            counter_clear <= 1'b0;
          end
        end
        INTEGRATE: begin
          if (!capture_en) begin
            st            <= IDLE;
            counter_clear <= 1'b1;
          end else if (cnt == last_cnt) begin
            st          <= LATCH;
            frame_latch <= 1'b1;
            tx_start    <= !tx_busy;
            if (tx_busy && overrun != 8'hff) overrun <= overrun + 8'd1;
          end else begin
            cnt <= cnt + PERIOD_BITS'(1);
          end
        end
        LATCH: begin
          st            <= CLEAR;
          counter_clear <= 1'b1;
        end
        CLEAR: begin
          cnt <= '0;
          if (capture_en) begin
            st            <= INTEGRATE;
            counter_clear <= 1'b0;
          end else begin
            st            <= IDLE;
            counter_clear <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_correlator_sequencer.sv
// Bench for correlator_sequencer: directed scenarios plus random command traffic,
// checked every cycle against a window-phase reference model.

module tb_correlator_sequencer;
  localparam int NI = 4, DB = 20, PB = 32, DN = DB / 4, PN = PB / 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0, tx_busy = 1'b0;
  logic [NI*DB-1:0]  delay;
  logic [31:0]       leds;
  logic [3:0]        baud_rate;
  logic              counter_clear, frame_latch, tx_start;
  logic [7:0]        overrun;
  logic [1:0]        state;

  correlator_sequencer #(.NUM_INPUTS(NI), .DELAY_BITS(DB), .PERIOD_BITS(PB)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .delay(delay), .leds(leds), .baud_rate(baud_rate), .counter_clear(counter_clear),
    .frame_latch(frame_latch), .tx_start(tx_start), .overrun(overrun), .state(state));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a window is tracked as a phase count since its start;
  // phases [0,eff) integrate, eff is the latch slot, eff+1 the clear slot.
  bit          m_win, m_cap, m_ts;
  int          m_ph, m_idx, m_ridx, m_baud, m_ovr;
  logic [PB-1:0] m_per;
  logic [31:0] m_leds;
  logic [DB-1:0] m_pend[NI], m_dly[NI];

  function automatic int m_eff();
    return (m_per < 2) ? 2 : int'(m_per);
  endfunction

  function automatic int m_state();
    if (!m_win) return 0;
    if (m_ph < m_eff()) return 1;
    if (m_ph == m_eff()) return 2;
    return 3;
  endfunction

  function automatic void model_reset();
    m_win = 0; m_cap = 0; m_ts = 0; m_ph = 0; m_idx = 0; m_ridx = 0;
    m_baud = 0; m_ovr = 0; m_per = '0; m_leds = '0;
    for (int i = 0; i < NI; i++) begin m_pend[i] = '0; m_dly[i] = '0; end
  endfunction

  function automatic void model_step();
    int e = m_eff();
    logic [3:0] op = rx_data[3:0];
    logic [3:0] arg = rx_data[7:4];
    m_ts = 0;
    if (!m_win) begin
      if (m_cap) begin m_win = 1; m_ph = 0; m_dly = m_pend; end
    end else if (m_ph < e) begin
      if (!m_cap) m_win = 0;
      else begin
        if (m_ph == e - 1) begin
          m_ts = !tx_busy;
          if (tx_busy && m_ovr < 255) m_ovr++;
        end
        m_ph++;
      end
    end else if (m_ph == e) begin
      m_ph++;
    end else begin
      m_dly = m_pend;
      if (m_cap) m_ph = 0; else m_win = 0;
    end
    if (rx_valid) begin
      case (op)
        4'd0: m_ridx = 0;
        4'd1: m_idx = int'(arg);
        4'd2: m_leds = (m_leds & ~(32'h3 << (2 * m_idx))) | (32'(arg[1:0]) << (2 * m_idx));
        4'd3: m_baud = int'(arg);
        4'd4: if (m_ridx < DN && m_idx < NI) begin
          m_pend[m_idx] = (m_pend[m_idx] & ~(DB'(15) << (4 * m_ridx))) | (DB'(arg) << (4 * m_ridx));
          m_ridx++;
        end
        4'd5: if (m_ridx < PN) begin
          m_per = (m_per & ~(PB'(15) << (4 * m_ridx))) | (PB'(arg) << (4 * m_ridx));
          m_ridx++;
        end
        4'd13: m_cap = arg[0];
        default: ;
      endcase
    end
  endfunction

  task automatic check_all();
    int st = m_state();
    logic [NI*DB-1:0] ed;
    for (int i = 0; i < NI; i++) ed[i*DB +: DB] = m_dly[i];
    chk("state", state, st);
    chk("frame_latch", frame_latch, st == 2);
    chk("tx_start", tx_start, m_ts);
    chk("counter_clear", counter_clear, st == 0 || st == 3);
    chk("delay", delay, ed);
    chk("leds", leds, m_leds);
    chk("baud_rate", baud_rate, m_baud);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v; rx_data = d;
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    cyc++;
    #1 check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  task automatic cmd(input logic [3:0] op, input logic [3:0] arg);
    tick(1'b1, {arg, op});
  endtask

  task automatic wait_state(input int s, input string tag);
    int w = 0;
    while (m_state() != s && w < 100) begin idle(1); w++; end
    chk(tag, w < 100, 1'b1);
  endtask

  initial begin
    int last, n, nts;
    bit prev_fl;
    logic [3:0] ops[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd13, 4'd13, 4'd7, 4'd15};

    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1 check_all();
    reset_n = 1'b1;
    idle(3);

    // period 4, capture on: latch + tx_start every 6 cycles, clear right after
    cmd(0, 0); cmd(5, 4); cmd(5, 0); cmd(13, 1);
    last = -1; n = 0; prev_fl = 0;
    repeat (40) begin
      idle(1);
      if (prev_fl) chk("clear_after_latch", counter_clear, 1'b1);
      if (frame_latch) begin
        if (last >= 0) chk("latch_gap6", cyc - last, 6);
        chk("tx_start_with_latch", tx_start, 1'b1);
        last = cyc; n++;
      end
      prev_fl = frame_latch;
    end
    chk("latch_count38", n >= 5, 1'b1);

    // delay nibbles written mid-window; sixth ignored
    cmd(1, 2); cmd(0, 0);
    cmd(4, 4'h5); cmd(4, 4'hA); cmd(4, 4'h3); cmd(4, 4'h0); cmd(4, 4'h0); cmd(4, 4'h7);
    idle(14);
    chk("delay2_final", delay[2*DB +: DB], 20'h003A5);

    // capture disabled mid-integrate: back to IDLE, no latch
    n = 0;
    begin
      int w = 0;
      while (!(m_state() == 1 && m_ph == 1) && w < 100) begin idle(1); w++; end
      chk("wait_integrate", w < 100, 1'b1);
    end
    cmd(13, 0);
    repeat (10) begin idle(1); if (frame_latch) n++; end
    chk("no_latch_after_disable", n, 0);
    chk("idle_clear", counter_clear, 1'b1);

    // period 0: 4-cycle repeat
    cmd(0, 0); cmd(5, 0); cmd(13, 1);
    last = -1; n = 0;
    repeat (30) begin
      idle(1);
      if (frame_latch) begin
        if (last >= 0) chk("latch_gap4", cyc - last, 4);
        last = cyc; n++;
      end
    end
    chk("latch_count41", n >= 6, 1'b1);

    // tx_busy held high for > 300 windows
    tx_busy = 1'b1;
    n = 0; nts = 0;
    repeat (1300) begin
      idle(1);
      if (frame_latch) n++;
      if (tx_start) nts++;
    end
    chk("busy_no_tx_start", nts, 0);
    chk("busy_latches", n >= 300, 1'b1);
    chk("overrun_sat", overrun, 8'd255);
    tx_busy = 1'b0;

    // asynchronous reset while in LATCH
    wait_state(2, "wait_latch");
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    idle(2);
    reset_n = 1'b1;
    n = 0; nts = 0;
    repeat (20) begin
      idle(1);
      if (frame_latch) n++;
      if (tx_start) nts++;
    end
    chk("post_reset_no_latch", n, 0);
    chk("post_reset_no_tx", nts, 0);

    // random command traffic with period 3
    cmd(0, 0); cmd(5, 3); cmd(13, 1);
    repeat (2500) begin
      tx_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        cmd(ops[$urandom_range(0, 8)], 4'($urandom_range(0, 15)));
      else
        idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/correlator_sequencer.md
CORRELATOR_SEQUENCER -- requirements
Module: correlator_sequencer

Interface
REQ-001 Parameter NUM_INPUTS, default 4, number of telescope inputs.
REQ-002 Parameter DELAY_BITS, default 20, delay-line tap index width (multiple of 4).
REQ-003 Parameter PERIOD_BITS, default 32, integration period width in clk cycles (multiple of 4).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, sole clock.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port rx_data, input, 8, command byte: [3:0] opcode, [7:4] argument.
REQ-008 Port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-009 Port tx_busy, input, 1, frame transmitter is busy.
REQ-010 Port delay, output, NUM_INPUTS*DELAY_BITS, active tap per input; input i is at [i*DELAY_BITS+:DELAY_BITS].
REQ-011 Port leds, output, 32, LED pairs.
REQ-012 Port baud_rate, output, 4, UART divider shift.
REQ-013 Port counter_clear, output, 1, synchronous clear for all pulse counters.
REQ-014 Port frame_latch, output, 1, one-cycle pulse: snapshot the counters into the transmit buffer.
REQ-015 Port tx_start, output, 1, one-cycle pulse: begin frame transmission.
REQ-016 Port overrun, output, 8, saturating count of dropped frames.
REQ-017 Port state, output, 2, current FSM state (IDLE=0, INTEGRATE=1, LATCH=2, CLEAR=3).

Function
REQ-018 Commands SHALL decode only on cycles with rx_valid=1. Unknown opcodes are ignored.
REQ-019 CLEAR (0) SHALL zero the nibble pointer ridx.
REQ-020 SET_INDEX (1) SHALL load index <= arg.
REQ-021 SET_LEDS (2) SHALL load leds[index*2+:2] <= arg[1:0]; index>15 is ignored.
REQ-022 SET_BAUD_RATE (3) SHALL load baud_rate <= arg.
REQ-023 SET_DELAY (4) SHALL write arg into pending_delay[index] nibble ridx, then increment ridx.
- ridx >= DELAY_BITS/4: write ignored, ridx holds.
- index >= NUM_INPUTS: write ignored.
REQ-024 SET_PERIOD (5) SHALL write arg into the period register nibble ridx, then increment ridx. ridx >= PERIOD_BITS/4: write ignored.
REQ-025 ENABLE_CAPTURE (13) SHALL load capture_en <= arg[0].
REQ-026 pending_delay values SHALL transfer to delay only in two cases:
- the IDLE->INTEGRATE transition;
- the CLEAR state.
A delay therefore never changes inside an integration window.
REQ-027 IDLE: counter_clear=1. When capture_en=1, go to INTEGRATE with cnt=0.
REQ-028 INTEGRATE: counter_clear=0 and cnt increments each cycle.
- When cnt == eff_period-1, go to LATCH.
- When capture_en=0, go to IDLE without latching.
REQ-029 eff_period SHALL be max(period, 2). A period of 0 or 1 gives a 2-cycle window.
REQ-030 LATCH SHALL last one cycle with frame_latch=1, then go to CLEAR.
- If tx_busy=0 in that cycle: tx_start=1 in the same cycle.
- If tx_busy=1: tx_start=0, and overrun increments, saturating at 255.
REQ-031 CLEAR SHALL last one cycle with counter_clear=1 and cnt<=0.
- Next state is INTEGRATE if capture_en=1, otherwise IDLE.
REQ-032 Window length SHALL be eff_period INTEGRATE cycles plus 2 (LATCH, CLEAR). No window is skipped.
REQ-033 A command and a state transition in the same cycle SHALL both take effect.
- A delay transfer in that cycle uses the pending value from before the command.
- A period write in that cycle applies from the next comparison.
REQ-034 ENABLE_CAPTURE 0 while in LATCH SHALL NOT suppress that frame; the FSM exits to IDLE from CLEAR.
REQ-035 All outputs SHALL be registered. frame_latch and tx_start assert in the cycle the FSM is in LATCH.

Reset
REQ-036 reset_n=0 SHALL asynchronously set the following values:
- state=IDLE, counter_clear=1;
- frame_latch=0, tx_start=0;
- delay=0, pending_delay=0;
- period=0, cnt=0;
- leds=0, baud_rate=0, index=0, ridx=0;
- capture_en=0, overrun=0.
REQ-037 Reset mid-window SHALL abort with no frame_latch/tx_start pulse. The first window after release starts only on a new ENABLE_CAPTURE 1.

Verification
REQ-038 Scenario: SET_PERIOD nibbles 0x4,0x0 after CLEAR (period=4), then ENABLE_CAPTURE 1, tx_busy=0 -> required response:
- frame_latch and tx_start every 6 cycles;
- counter_clear high for 1 cycle after each latch.
REQ-039 Scenario: tx_busy=1 throughout 300 windows -> required response:
- tx_start never asserts;
- frame_latch still pulses;
- overrun saturates at 255.
REQ-040 Scenario: SET_INDEX 2, CLEAR, SET_DELAY 0x5,0xA,0x3,0x0,0x0,0x7 mid-window -> required response:
- delay[2] stays old until CLEAR state, then becomes 0x003A5;
- sixth nibble ignored.
REQ-041 Scenario: period=0 -> required response: windows of 2 INTEGRATE cycles plus LATCH and CLEAR (4-cycle repeat).
REQ-042 Scenario: ENABLE_CAPTURE 0 during INTEGRATE -> required response:
- IDLE next cycle;
- no frame_latch;
- counter_clear=1.
REQ-043 Scenario: reset_n low asynchronously during LATCH -> required response:
- all outputs at reset values immediately;
- no tx_start pulse after release until re-enable.
